// File: rtl/reader_inv_sched.sv
`timescale 1ns/1ps
// Inventory-round scheduler: issues QUERY/QUERYREP/ACK/NAK and collects RN16/EPC replies.
// Latency: command issued 1 cycle after start/decision; EPC accepted 2 cycles after tag_finish
//          (EPC_LEN cycles with the serial CRC check).
// Backpressure: cmd_valid/cmd_type/cmd_arg are held stable until cmd_ready; nothing else stalls.
//
// Ports:
//   CLK, RESET                   clock, synchronous active-high reset
//   start, testcase              round start pulse and sequence select (latched at start)
//   cmd_valid/ready, cmd_type,   command handshake to the TX encoder (0=QUERY 1=QUERYREP
//   cmd_arg                      2=ACK 3=NAK; cmd_arg carries the RN16 for ACK)
//   tx_done                      TX encoder finished the frame
//   tag_finish, tag_data,        decoded tag reply from the pulse counter
//   tag_data_number
//   rx_clear                     one-cycle clear of the pulse counter before each reply window
//   busy, done                   round in progress / round complete pulse
//   epc_out, epc_valid           last accepted EPC and its update strobe
//   tag_cnt, err_cnt             per-round statistics, saturating at 255
//
// Optional feature: define READER_INV_SCHED_CRC16_EN to verify the EPC CRC-16 serially
// (MSB-first, preset 0xFFFF, residue 0x1D0F) before accepting it.
module reader_inv_sched #(
    parameter int TIMEOUT_CYC = 4096,
    parameter int MAX_RETRY   = 3,
    parameter int NUM_SLOTS   = 8,
    parameter int RN16_LEN    = 16,
    parameter int EPC_LEN     = 128
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               start,
    input  logic [1:0]         testcase,
    output logic               cmd_valid,
    input  logic               cmd_ready,
    output logic [2:0]         cmd_type,
    output logic [15:0]        cmd_arg,
    input  logic               tx_done,
    input  logic               tag_finish,
    input  logic [255:0]       tag_data,
    input  logic [15:0]        tag_data_number,
    output logic               rx_clear,
    output logic               busy,
    output logic               done,
    output logic [EPC_LEN-1:0] epc_out,
    output logic               epc_valid,
    output logic [7:0]         tag_cnt,
    output logic [7:0]         err_cnt
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int RW = $clog2(MAX_RETRY + 1);
    localparam int SW = $clog2(NUM_SLOTS + 1);

    localparam logic [2:0] CMD_QUERY    = 3'd0;
    localparam logic [2:0] CMD_QUERYREP = 3'd1;
    localparam logic [2:0] CMD_ACK      = 3'd2;
    localparam logic [2:0] CMD_NAK      = 3'd3;

    typedef enum logic [2:0] {
        IDLE, ISSUE, WAIT_TX, WAIT_RN16, WAIT_EPC, CHECK, NEXT, FIN
    } state_t;

    state_t             state, state_nxt;
    logic [TW-1:0]      timer;
    logic [RW-1:0]      retry;
    logic [SW-1:0]      slot;
    logic [1:0]         tc;
    logic [EPC_LEN-1:0] epc_buf;

    // Decision strobes from the next-state logic to the datapath.
    logic       ld_cmd;
    logic [2:0] cmd_nxt;
    logic       err_inc, retry_inc, retry_clr, epc_ld, epc_fail, accept;
    logic       slot_inc, timer_clr, round_clr, rx_pulse, fin;

    logic timeout, retry_left, rn_len_ok, epc_len_ok;

    // Only the EPC-sized low part of the reply bus is ever consumed.
    logic unused_tag_hi;
    assign unused_tag_hi = ^tag_data[255:EPC_LEN];

    assign timeout    = (timer == TW'(TIMEOUT_CYC - 1));
    assign retry_left = (retry < RW'(MAX_RETRY));
    assign rn_len_ok  = (tag_data_number == 16'(RN16_LEN));
    assign epc_len_ok = (tag_data_number == 16'(EPC_LEN));

    // The command is presented for exactly as long as the FSM sits in ISSUE, so a reset
    // (which forces IDLE) withdraws it on the following cycle.
    assign cmd_valid = (state == ISSUE);

`ifdef READER_INV_SCHED_CRC16_EN
    localparam int CW = $clog2(EPC_LEN);

    logic [15:0]   crc;
    logic [CW-1:0] crc_idx;
    logic [15:0]   crc_last;
    logic          crc_done;

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
        crc_step = {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
    endfunction

    // The MSB is folded in on the tag_finish edge, so CHECK needs only EPC_LEN-1 cycles and
    // epc_valid lands exactly EPC_LEN cycles after tag_finish.
    assign crc_last = crc_step(crc, epc_buf[crc_idx]);
    assign crc_done = (crc_idx == '0);
`endif

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ld_cmd    = 1'b0;
        cmd_nxt   = cmd_type;
        err_inc   = 1'b0;
        retry_inc = 1'b0;
        retry_clr = 1'b0;
        epc_ld    = 1'b0;
        epc_fail  = 1'b0;
        accept    = 1'b0;
        slot_inc  = 1'b0;
        timer_clr = 1'b0;
        round_clr = 1'b0;
        rx_pulse  = 1'b0;
        fin       = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    round_clr = 1'b1;
                    ld_cmd    = 1'b1;
                    cmd_nxt   = CMD_QUERY;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (cmd_ready) begin
                    state_nxt = WAIT_TX;
                end
            end
            WAIT_TX: begin
                if (tx_done) begin
                    rx_pulse  = 1'b1;
                    timer_clr = 1'b1;
                    case (cmd_type)
                        CMD_QUERY, CMD_QUERYREP: state_nxt = WAIT_RN16;
                        CMD_ACK:                 state_nxt = WAIT_EPC;
                        default:                 state_nxt = NEXT;
                    endcase
                end
            end
            WAIT_RN16: begin
                // A reply on the timeout cycle is checked first, so it wins.
                if (tag_finish && rn_len_ok) begin
                    retry_clr = 1'b1;
                    if (tc == 2'd0) begin
                        state_nxt = NEXT;
                    end else begin
                        ld_cmd    = 1'b1;
                        cmd_nxt   = CMD_ACK;
                        state_nxt = ISSUE;
                    end
                end else if (tag_finish || timeout) begin
                    err_inc = 1'b1;
                    if (retry_left) begin
                        retry_inc = 1'b1;
                        state_nxt = ISSUE;
                    end else begin
                        state_nxt = NEXT;
                    end
                end
            end
            WAIT_EPC: begin
                if (tag_finish && epc_len_ok) begin
                    epc_ld    = 1'b1;
                    state_nxt = CHECK;
                end else if (tag_finish || timeout) begin
                    epc_fail = 1'b1;
                end
            end
            CHECK: begin
`ifdef READER_INV_SCHED_CRC16_EN
                if (crc_done) begin
                    if (crc_last == 16'h1D0F) begin
                        accept    = 1'b1;
                        state_nxt = NEXT;
                    end else begin
                        epc_fail = 1'b1;
                    end
                end
`else
                accept    = 1'b1;
                state_nxt = NEXT;
`endif
            end
            NEXT: begin
                slot_inc  = 1'b1;
                retry_clr = 1'b1;
                if (!tc[1] || slot == SW'(NUM_SLOTS - 1)) begin
                    state_nxt = FIN;
                end else begin
                    ld_cmd    = 1'b1;
                    cmd_nxt   = CMD_QUERYREP;
                    state_nxt = ISSUE;
                end
            end
            FIN: begin
                fin       = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        // Bad EPC (wrong length, silence or CRC failure): re-ACK with the same RN16 until the
        // retry budget runs out, then NAK the tag (testcase 3) or just move on.
        if (epc_fail) begin
            err_inc = 1'b1;
            if (retry_left) begin
                retry_inc = 1'b1;
                state_nxt = ISSUE;
            end else if (tc == 2'd3) begin
                ld_cmd    = 1'b1;
                cmd_nxt   = CMD_NAK;
                state_nxt = ISSUE;
            end else begin
                state_nxt = NEXT;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            timer     <= '0;
            retry     <= '0;
            slot      <= '0;
            tc        <= '0;
            epc_buf   <= '0;
            cmd_type  <= CMD_QUERY;
            cmd_arg   <= '0;
            rx_clear  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            epc_out   <= '0;
            epc_valid <= 1'b0;
            tag_cnt   <= '0;
            err_cnt   <= '0;
        end else begin
            rx_clear  <= rx_pulse;
            done      <= fin;
            epc_valid <= accept;

            if (round_clr) begin
                tc      <= testcase;
                tag_cnt <= '0;
                err_cnt <= '0;
                slot    <= '0;
                busy    <= 1'b1;
            end else if (fin) begin
                busy <= 1'b0;
            end

            // The RN16 is latched straight into cmd_arg when the ACK is loaded; ACK retries
            // leave cmd_arg untouched so the same handle is re-sent.
            if (ld_cmd) begin
                cmd_type <= cmd_nxt;
                cmd_arg  <= (cmd_nxt == CMD_ACK) ? tag_data[15:0] : 16'h0000;
            end

            if (round_clr || retry_clr) begin
                retry <= '0;
            end else if (retry_inc) begin
                retry <= retry + 1'b1;
            end

            if (slot_inc) begin
                slot <= slot + 1'b1;
            end

            if (timer_clr) begin
                timer <= '0;
            end else if (state == WAIT_RN16 || state == WAIT_EPC) begin
                timer <= timer + 1'b1;
            end

            if (err_inc && err_cnt != 8'hFF) begin
                err_cnt <= err_cnt + 8'd1;
            end

            if (epc_ld) begin
                epc_buf <= tag_data[EPC_LEN-1:0];
            end

            if (accept) begin
                epc_out <= epc_buf;
                if (tag_cnt != 8'hFF) begin
                    tag_cnt <= tag_cnt + 8'd1;
                end
            end
        end
    end

`ifdef READER_INV_SCHED_CRC16_EN
    always_ff @(posedge CLK) begin
        if (RESET) begin
            crc     <= 16'hFFFF;
            crc_idx <= '0;
        end else if (epc_ld) begin
            crc     <= crc_step(16'hFFFF, tag_data[EPC_LEN-1]);
            crc_idx <= CW'(EPC_LEN - 2);
        end else if (state == CHECK) begin
            crc     <= crc_last;
            crc_idx <= crc_idx - 1'b1;
        end
    end
`endif

endmodule

// File: doc/reader_inv_sched.md
Name: reader_inv_sched

Overview:
- Inventory-round scheduler for the RTL UHF reader.
- Sequences reader commands (Query / QueryRep / ACK / NAK) to the reader TX encoder.
- Consumes the pulse counter's decoded tag reply (data, bit count, finish strobe), applies timeouts and retries, and reports captured EPCs and round statistics.
- Sits between the testcase selector and the reader_cdr / pulse_cnt pair.

Parameters:
- TIMEOUT_CYC, 4096: reply-wait limit in CLK cycles.
- MAX_RETRY, 3: re-sends per slot before abandoning it.
- NUM_SLOTS, 8: slots per full round (testcase 2/3).
- RN16_LEN, 16: expected RN16 reply bit count.
- EPC_LEN, 128: expected EPC reply bit count (PC+EPC+CRC16).

Ports:
- CLK  in  1  6.4 MHz system clock.
- RESET  in  1  synchronous, active-high reset.
- start  in  1  one-cycle round start request.
- testcase  in  2  sequence select.
- cmd_valid  out  1  command request to TX encoder.
- cmd_ready  in  1  TX encoder accepts command.
- cmd_type  out  3  0=QUERY, 1=QUERYREP, 2=ACK, 3=NAK.
- cmd_arg  out  16  RN16 for ACK, else 0.
- tx_done  in  1  pulse: frame fully transmitted.
- tag_finish  in  1  pulse: tag reply decoded.
- tag_data  in  256  decoded reply, LSB = last bit received.
- tag_data_number  in  16  reply bit count.
- rx_clear  out  1  pulse: clear pulse counter before reply window.
- busy  out  1  round in progress.
- done  out  1  pulse: round complete.
- epc_out  out  EPC_LEN  last accepted EPC reply.
- epc_valid  out  1  pulse: epc_out updated.
- tag_cnt  out  8  EPCs accepted this round, saturating at 255.
- err_cnt  out  8  timeouts and bad replies, saturating at 255.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; slot, retry and timer counters 0. Reset mid-round aborts the round immediately, with cmd_valid low on the next cycle.
- States: IDLE, ISSUE, WAIT_TX, WAIT_RN16, WAIT_EPC, CHECK, NEXT, FIN.
- IDLE:
  - start=1 → clear tag_cnt, err_cnt, slot, retry; busy=1; load QUERY; go ISSUE.
  - start while busy is ignored.
- ISSUE:
  - cmd_valid=1, with cmd_type and cmd_arg held stable until cmd_valid & cmd_ready.
  - On that cycle cmd_valid drops next edge → WAIT_TX.
- WAIT_TX:
  - On tx_done, rx_clear pulses one cycle.
  - Then go to WAIT_RN16 after QUERY/QUERYREP, WAIT_EPC after ACK, NEXT after NAK.
- Timer: reset to 0 on entry to each WAIT_RN16/WAIT_EPC, +1 per cycle. Timeout when timer == TIMEOUT_CYC-1 without tag_finish.
- tag_finish and timeout in the same cycle: tag_finish wins. tag_finish in any other state is ignored.
- WAIT_RN16:
  - tag_finish with tag_data_number==RN16_LEN → latch RN16=tag_data[15:0], retry=0.
    - testcase 0 → NEXT.
    - Otherwise → ISSUE ACK, cmd_arg=RN16.
  - Wrong length or timeout → err_cnt+1.
    - retry<MAX_RETRY → retry+1, re-ISSUE same command.
    - Else → NEXT.
- WAIT_EPC:
  - tag_finish with tag_data_number==EPC_LEN → CHECK.
  - Wrong length or timeout → err_cnt+1; retry ACK as above.
    - On retry exhaustion: testcase 3 → ISSUE NAK; else → NEXT.
- CHECK (1 cycle without the optional feature):
  - epc_out = tag_data[EPC_LEN-1:0], epc_valid pulse, tag_cnt+1 → NEXT.
- NEXT:
  - slot+1, retry=0.
  - testcase 0/1 → FIN after slot 0.
  - testcase 2/3 → FIN when slot==NUM_SLOTS-1, else ISSUE QUERYREP.
- FIN: done pulses one cycle, busy=0 → IDLE.
- Counters saturate at 255; no wrap.

Optional Feature:
- Macro: READER_INV_SCHED_CRC16_EN.
- When defined, CHECK runs serially, one bit per cycle over tag_data[EPC_LEN-1:0] MSB-first.
  - CRC: CRC-16/CCITT, poly 0x1021, preset 0xFFFF; EPC_LEN cycles.
  - Residue 0x1D0F → accept: epc_out, epc_valid, tag_cnt as above.
  - Otherwise → err_cnt+1 and handled as a bad EPC reply (ACK retry path).
- Not defined: CHECK is a single cycle and any length-correct reply is accepted.

Test Plan:
- testcase=1, start; tag replies 16 bits 0xA5C3, then 128-bit EPC → QUERY, then ACK with cmd_arg=0xA5C3; epc_valid once; tag_cnt=1, err_cnt=0; done.
- testcase=0, start; no tag_finish → QUERY issued 4 times (1+MAX_RETRY), each wait exactly 4096 cycles; err_cnt=4; done; cmd_type never ACK.
- testcase=2, 8 slots, tag responds in slots 2 and 5 only (other slots silent) → 1 QUERY + 7 QUERYREP issued; tag_cnt=2; err_cnt=24 (6 silent slots × 4 attempts); done after the 8th slot.
- cmd_ready held low 50 cycles during ISSUE → cmd_valid, cmd_type, cmd_arg stable for all 50 cycles; exactly one transfer.
- tag_finish on the exact timeout cycle with a 16-bit reply → accepted as RN16; err_cnt unchanged. RESET asserted in WAIT_EPC → busy=0, cmd_valid=0, counters 0 next cycle.
- With READER_INV_SCHED_CRC16_EN: EPC with one corrupted bit → err_cnt+1 and ACK re-sent. A valid-CRC EPC → epc_valid exactly EPC_LEN cycles after tag_finish.
